filter_trigger_sequencer: RTL

Sequencer for one self-triggering IIR filter channel. It drives the filter's `enable` and `n_1_reset` inputs and rising-edge-detects the filter's level `trigger` output. Each accepted trigger opens a fixed-length capture window, followed by a dead time, with an optional flush/settle step when the channel is (re)armed. It sits between the channel's ADC sample strobe, the filter instance, and the capture buffer writer.

---
 rtl/filter_trigger_sequencer_if.sv | 31 +++
 rtl/filter_trigger_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/filter_trigger_sequencer_if.sv
// Signal bundle between the trigger sequencer, its filter channel and the capture writer.
// The master drives the sequencer's inputs; the slave side is the sequencer itself.
interface filter_trigger_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             sample_valid;
  logic             filt_trigger;
  logic             counts_clear;
  logic             filt_enable;
  logic             filt_n_1_reset;
  logic             capture_start;
  logic             capture_valid;
  logic             capture_last;
  logic             busy;
  logic [2:0]       state;
  logic [CNT_W-1:0] trig_count;
  logic [CNT_W-1:0] missed_count;

  modport master (
    output run, sample_valid, filt_trigger, counts_clear,
    input  filt_enable, filt_n_1_reset, capture_start, capture_valid,
    input  capture_last, busy, state, trig_count, missed_count
  );

  modport slave (
    input  run, sample_valid, filt_trigger, counts_clear,
    output filt_enable, filt_n_1_reset, capture_start, capture_valid,
    output capture_last, busy, state, trig_count, missed_count
  );
endinterface

// File: rtl/filter_trigger_sequencer.sv
// Arms one self-triggering IIR channel, turns trigger edges into fixed-length capture
// windows with a dead time, and keeps saturating accepted/missed trigger counts.
module filter_trigger_sequencer #(
  parameter int FLUSH_LEN   = 2,
  parameter int SETTLE_LEN  = 64,
  parameter int CAPTURE_LEN = 512,
  parameter int DEAD_LEN    = 128,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  filter_trigger_sequencer_if.slave    io
);

  localparam int MAX_FS  = (FLUSH_LEN > SETTLE_LEN) ? FLUSH_LEN : SETTLE_LEN;
  localparam int MAX_CD  = (CAPTURE_LEN > DEAD_LEN) ? CAPTURE_LEN : DEAD_LEN;
  localparam int MAX_LEN = (MAX_FS > MAX_CD) ? MAX_FS : MAX_CD;
  localparam int SEQ_W   = $clog2(MAX_LEN) + 1;

  localparam logic [SEQ_W-1:0] FLUSH_LAST   = SEQ_W'(FLUSH_LEN - 1);
  localparam logic [SEQ_W-1:0] SETTLE_LAST  = SEQ_W'(SETTLE_LEN - 1);
  localparam logic [SEQ_W-1:0] CAPTURE_LAST = SEQ_W'(CAPTURE_LEN - 1);
  localparam logic [SEQ_W-1:0] DEAD_LAST    = SEQ_W'(DEAD_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_SETTLE  = 3'd2,
    S_ARMED   = 3'd3,
    S_CAPTURE = 3'd4,
    S_DEAD    = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [SEQ_W-1:0] seq_cnt_reg, seq_cnt_next;
  logic             trig_d_reg;
  logic             capture_start_reg, capture_start_next;
  logic             trig_edge;
  logic [1:0]       cnt_inc;   // [0] accepted trigger, [1] missed trigger

  assign trig_edge = io.filt_trigger & ~trig_d_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      seq_cnt_reg       <= '0;
      trig_d_reg        <= 1'b0;
      capture_start_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      seq_cnt_reg       <= seq_cnt_next;
      trig_d_reg        <= io.filt_trigger;
      capture_start_reg <= capture_start_next;
    end
  end

  // FLUSH counts clocks; SETTLE, CAPTURE and DEAD count sample strobes only.
  always_comb begin
    state_next         = state_reg;
    seq_cnt_next       = seq_cnt_reg;
    capture_start_next = 1'b0;
    cnt_inc            = 2'b00;
    case (state_reg)
      S_IDLE: begin
        if (io.run) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (!io.run)                        state_next = S_IDLE;
        else if (seq_cnt_reg == FLUSH_LAST) state_next = S_SETTLE;
        else                                seq_cnt_next = seq_cnt_reg + 1'b1;
      end
      S_SETTLE: begin
        if (!io.run) begin
          state_next = S_IDLE;
        end else if (io.sample_valid) begin
          if (seq_cnt_reg == SETTLE_LAST) state_next = S_ARMED;
          else                            seq_cnt_next = seq_cnt_reg + 1'b1;
        end
      end
      S_ARMED: begin
        // A trigger edge beats a simultaneous drop of run.
        if (trig_edge) begin
          state_next         = S_CAPTURE;
          capture_start_next = 1'b1;
          cnt_inc[0]         = 1'b1;
        end else if (!io.run) begin
          state_next = S_IDLE;
        end
      end
      S_CAPTURE: begin
        cnt_inc[1] = trig_edge;
        if (io.sample_valid) begin
          if (seq_cnt_reg == CAPTURE_LAST) state_next = S_DEAD;
          else                             seq_cnt_next = seq_cnt_reg + 1'b1;
        end
      end
      S_DEAD: begin
        cnt_inc[1] = trig_edge;
        if (io.sample_valid) begin
          if (seq_cnt_reg == DEAD_LAST) state_next = io.run ? S_ARMED : S_IDLE;
          else                          seq_cnt_next = seq_cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (state_next != state_reg) seq_cnt_next = '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_status
      logic [CNT_W-1:0] cnt_reg, cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (io.counts_clear)
          cnt_next = CNT_W'(cnt_inc[gi]);
        else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
          cnt_next = cnt_reg + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (reset) cnt_reg <= '0;
        else       cnt_reg <= cnt_next;
      end
    end
  endgenerate

  logic filt_active;
  assign filt_active = (state_reg == S_SETTLE) || (state_reg == S_ARMED) ||
                       (state_reg == S_CAPTURE) || (state_reg == S_DEAD);

  assign io.filt_enable    = io.sample_valid & filt_active;
  assign io.filt_n_1_reset = (state_reg == S_IDLE) || (state_reg == S_FLUSH);
  assign io.capture_start  = capture_start_reg;
  assign io.capture_valid  = io.sample_valid & (state_reg == S_CAPTURE);
  assign io.capture_last   = io.capture_valid & (seq_cnt_reg == CAPTURE_LAST);
  assign io.busy           = (state_reg != S_IDLE);
  assign io.state          = state_reg;
  assign io.trig_count     = g_status[0].cnt_reg;
  assign io.missed_count   = g_status[1].cnt_reg;

endmodule
